ex_div: RTL and testbench
=========================

# ex_div

Multi-cycle 32/32 radix-2 divider serving DIV/DIVU in the EX stage. It raises `stallreq_o` to the pipeline controller while a division is in flight. It obeys the controller's `flush` and EX-stage stall outputs, so it sits on the requesting end of the stall/flush handshake. The result is written back as {remainder, quotient} into HI/LO.

## Interface
- No parameters; width fixed at 32.
- Clocking (already decided): one clock; reset is synchronous and active-high.
- `clk`  in  1  rising-edge clock
- `rst`  in  1  synchronous, active-high reset
- `flush`  in  1  pipeline flush from controller (exception or mispredict); abort
- `ex_stall_i`  in  1  EX stage held by controller (stall bit for EX)
- `start_i`  in  1  DIV/DIVU present in EX; held high with stable operands until accepted
- `signed_i`  in  1  1 = DIV (signed), 0 = DIVU
- `dividend_i`  in  32  rs operand
- `divisor_i`  in  32  rt operand
- `result_o`  out  64  {remainder[63:32], quotient[31:0]}; valid when `ready_o`
- `ready_o`  out  1  result valid
- `stallreq_o`  out  1  `start_i & ~ready_o & ~flush` (combinational)

## Operation
- States: FREE, BYZERO, ON, END.
- FREE:
  - `start_i` with divisor ≠ 0 → ON. Latch operand magnitudes, the sign of the quotient (signs differ) and the sign of the remainder (dividend sign). Clear the counter.
  - `start_i` with divisor = 0 → BYZERO.
- BYZERO → END. Result is 64'h0.
- ON:
  - One restoring step per cycle: a 33-bit trial subtract of the divisor from the partial remainder, then shift in the quotient bit.
  - 6-bit counter runs 0..31.
  - When the counter equals 31, apply sign fix-up and → END.
- Sign fix-up, signed only:
  - Quotient is negated if the operand signs differ.
  - Remainder takes the dividend's sign.
  - Both are two's-complement, 32-bit, with wrap allowed. 0x80000000 / 0xFFFFFFFF yields quotient 0x80000000, remainder 0.
- END:
  - `ready_o` = 1 and `result_o` holds the result.
  - → FREE when `ex_stall_i` = 0, i.e. the instruction advances. Otherwise stay in END with the result held.
- Flush, from any state: → FREE next cycle and `ready_o` = 0. Flush has priority over `start_i` and over the END hold.
- `result_o` is 0 in every state except END.

## Timing
- Reset: state FREE, `result_o` = 0, `ready_o` = 0, counter 0. `stallreq_o` follows `start_i`.
- Normal latency: accept in cycle 0 (FREE), iterate in cycles 1–32 (ON), END in cycle 33. `stallreq_o` is high in cycles 0–32 and low in cycle 33.
- Divide by zero: END in cycle 2.
- Back-to-back divides: the second op sees FREE one cycle after the first leaves END, then starts a fresh 33-cycle sequence.
- Flush asserted in the same cycle as start in FREE: no operation is accepted.
- Reset asserted mid-operation overrides everything; the block is in FREE the next cycle.
- Operands are sampled only at acceptance. Changes during ON are ignored.

## Configuration
- `DIV_EARLY_TERM_EN`:
  - Defined: in FREE, if the dividend magnitude is less than the divisor magnitude (divisor ≠ 0), go directly to END via a single intermediate cycle. Quotient = 0, remainder = signed dividend, latency 2 (same as BYZERO).
  - Undefined: always the full 33-cycle path.

## Structure
- Shared package/defines:
  - state encodings DivFree / DivByZero / DivOn / DivEnd
  - `DivResultReady` / `DivResultNotReady`
  - `DivStart` / `DivStop`
  - existing `Flush`, `Stop`, `ZeroWord`
- One sub-module, `div_iter_step`: combinational single restoring step. Inputs are the 65-bit working register and the 32-bit divisor; output is the next working register.

## Test plan
- DIVU 100 / 7 → `ready_o` in cycle 33, `result_o` = {32'd2, 32'd14}; `stallreq_o` high for cycles 0–32.
- DIV -7 / 2 → quotient 0xFFFFFFFD, remainder 0xFFFFFFFF; DIV 7 / -2 → quotient 0xFFFFFFFD, remainder 0x00000001.
- DIV 5 / 0 → END in cycle 2, `result_o` = 0, `ready_o` = 1.
- Start 0xFFFFFFFF / 3, flush in cycle 10 → FREE in cycle 11. `ready_o` never asserts; a new 9 / 3 then completes 33 cycles later with quotient 3, remainder 0.
- `ex_stall_i` held high for 4 cycles from cycle 33 → stays in END with `ready_o` = 1 and the result stable; FREE one cycle after `ex_stall_i` drops.
- With `DIV_EARLY_TERM_EN`: DIVU 3 / 10 → `ready_o` in cycle 2, `result_o` = {32'd3, 32'd0}; without the macro, cycle 33.

Source files
------------

// File: rtl/ex_div_pkg.sv
// Shared definitions for the EX-stage divider: state encodings, handshake
// levels and small helpers used by ex_div and its iteration step.
package ex_div_pkg;

  typedef enum logic [1:0] {
    DivFree   = 2'b00,
    DivByZero = 2'b01,
    DivOn     = 2'b10,
    DivEnd    = 2'b11
  } div_state_e;

  localparam logic DivResultReady    = 1'b1;
  localparam logic DivResultNotReady = 1'b0;
  localparam logic DivStart          = 1'b1;
  localparam logic DivStop           = 1'b0;
  localparam logic Flush             = 1'b1;
  localparam logic Stop              = 1'b1;

  localparam logic [31:0] ZeroWord    = 32'h0000_0000;
  localparam logic [5:0]  DivLastStep = 6'd31;

  // Two's-complement negate when neg is set; wraps for 0x80000000.
  function automatic logic [31:0] neg_if(input logic [31:0] v, input logic neg);
    return neg ? (~v + 32'd1) : v;
  endfunction

endpackage

// File: rtl/ex_div_iter.sv
// One restoring-division step. The working register holds the partial
// remainder in [63:32] and the not-yet-consumed dividend bits (which become
// quotient bits as they shift out) in [31:0]. Bit 64 is always zero.
module div_iter_step (
  input  logic [64:0] work_i,
  input  logic [31:0] divisor_i,
  output logic [64:0] work_o
);

  logic [32:0] rem_sh;
  logic [32:0] diff;
  logic        unused_msb;

  assign unused_msb = work_i[64];

  // Shift in the next dividend bit, trial-subtract, keep or restore.
  always_comb begin
    rem_sh = work_i[63:31];
    diff   = rem_sh - {1'b0, divisor_i};
    if (diff[32]) begin
      work_o = {1'b0, rem_sh[31:0], work_i[30:0], 1'b0};
    end else begin
      work_o = {1'b0, diff[31:0], work_i[30:0], 1'b1};
    end
  end

endmodule

// File: rtl/ex_div.sv
// Multi-cycle 32/32 radix-2 divider for DIV/DIVU in EX.
// Result is {remainder, quotient}, valid while ready_o is high.
// Optional feature: define DIV_EARLY_TERM_EN to finish in two cycles when
// the dividend magnitude is below the divisor magnitude.
module ex_div
  import ex_div_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        flush,
  input  logic        ex_stall_i,
  input  logic        start_i,
  input  logic        signed_i,
  input  logic [31:0] dividend_i,
  input  logic [31:0] divisor_i,
  output logic [63:0] result_o,
  output logic        ready_o,
  output logic        stallreq_o
);

  div_state_e  state_q, state_d;
  logic [5:0]  cnt_q, cnt_d;
  logic [64:0] work_q, work_d;
  logic [31:0] divisor_q, divisor_d;
  logic        neg_quot_q, neg_quot_d;
  logic        neg_rem_q, neg_rem_d;
  logic [63:0] result_q, result_d;

  logic [31:0] dvd_mag;
  logic [31:0] dvs_mag;
  logic [64:0] step_work;

  assign dvd_mag = neg_if(dividend_i, signed_i & dividend_i[31]);
  assign dvs_mag = neg_if(divisor_i, signed_i & divisor_i[31]);

  div_iter_step u_step (
    .work_i   (work_q),
    .divisor_i(divisor_q),
    .work_o   (step_work)
  );

  assign ready_o    = (state_q == DivEnd) ? DivResultReady : DivResultNotReady;
  assign result_o   = (state_q == DivEnd) ? result_q : {ZeroWord, ZeroWord};
  assign stallreq_o = (start_i == DivStart && ready_o == DivResultNotReady && flush != Flush)
                      ? DivStart : DivStop;

  // Next-state and datapath updates; flush overrides everything at the end.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    work_d     = work_q;
    divisor_d  = divisor_q;
    neg_quot_d = neg_quot_q;
    neg_rem_d  = neg_rem_q;
    result_d   = result_q;

    case (state_q)
      DivFree: begin
        if (start_i == DivStart) begin
          if (divisor_i == ZeroWord) begin
            state_d  = DivByZero;
            result_d = {ZeroWord, ZeroWord};
`ifdef DIV_EARLY_TERM_EN
          end else if (dvd_mag < dvs_mag) begin
            // Reuse the one-cycle wait state; quotient is zero, remainder is the dividend.
            state_d  = DivByZero;
            result_d = {dividend_i, ZeroWord};
`endif
          end else begin
            state_d    = DivOn;
            cnt_d      = '0;
            work_d     = {33'd0, dvd_mag};
            divisor_d  = dvs_mag;
            neg_quot_d = signed_i & (dividend_i[31] ^ divisor_i[31]);
            neg_rem_d  = signed_i & dividend_i[31];
          end
        end
      end
      DivByZero: begin
        state_d = DivEnd;
      end
      DivOn: begin
        work_d = step_work;
        cnt_d  = cnt_q + 6'd1;
        if (cnt_q == DivLastStep) begin
          state_d  = DivEnd;
          cnt_d    = '0;
          result_d = {neg_if(step_work[63:32], neg_rem_q),
                      neg_if(step_work[31:0], neg_quot_q)};
        end
      end
      DivEnd: begin
        if (ex_stall_i != Stop) begin
          state_d = DivFree;
        end
      end
      default: begin
        state_d = DivFree;
      end
    endcase

    if (flush == Flush) begin
      state_d = DivFree;
      cnt_d   = '0;
    end
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= DivFree;
      cnt_q      <= '0;
      work_q     <= '0;
      divisor_q  <= '0;
      neg_quot_q <= 1'b0;
      neg_rem_q  <= 1'b0;
      result_q   <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      work_q     <= work_d;
      divisor_q  <= divisor_d;
      neg_quot_q <= neg_quot_d;
      neg_rem_q  <= neg_rem_d;
      result_q   <= result_d;
    end
  end

endmodule

// File: tb/tb_ex_div.sv
// Self-checking bench for ex_div using an expected-result queue.
module tb_ex_div;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        flush = 1'b0;
  logic        ex_stall_i = 1'b0;
  logic        start_i = 1'b0;
  logic        signed_i = 1'b0;
  logic [31:0] dividend_i = '0;
  logic [31:0] divisor_i = '0;
  logic [63:0] result_o;
  logic        ready_o;
  logic        stallreq_o;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [63:0] res;
    int          lat;
  } exp_t;

  exp_t sb[$];

  ex_div dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .ex_stall_i(ex_stall_i),
    .start_i   (start_i),
    .signed_i  (signed_i),
    .dividend_i(dividend_i),
    .divisor_i (divisor_i),
    .result_o  (result_o),
    .ready_o   (ready_o),
    .stallreq_o(stallreq_o)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mag(input logic [31:0] v, input logic s);
    return (s && v[31]) ? (~v + 32'd1) : v;
  endfunction

  function automatic logic [63:0] model(input logic [31:0] a, input logic [31:0] b, input logic s);
    logic signed [31:0] sa, sb_, sq, sr;
    logic [31:0] q, r;
    if (b == 32'd0) return 64'd0;
    if (s) begin
      sa = a; sb_ = b;
      sq = sa / sb_;
      sr = sa % sb_;
      q = sq; r = sr;
    end else begin
      q = a / b;
      r = a % b;
    end
    return {r, q};
  endfunction

  function automatic int model_lat(input logic [31:0] a, input logic [31:0] b, input logic s);
    if (b == 32'd0) return 2;
`ifdef DIV_EARLY_TERM_EN
    if (mag(a, s) < mag(b, s)) return 2;
`endif
    return 33;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue_exp(input logic [31:0] a, input logic [31:0] b, input logic s,
                           input logic [63:0] res, input int lat);
    exp_t e;
    dividend_i = a;
    divisor_i  = b;
    signed_i   = s;
    start_i    = 1'b1;
    e.res = res;
    e.lat = lat;
    sb.push_back(e);
  endtask

  task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic s);
    issue_exp(a, b, s, model(a, b, s), model_lat(a, b, s));
  endtask

  // Counts cycles from acceptance (cycle 0) until ready_o; lat = -1 on timeout.
  task automatic wait_ready(output int lat, output int stall_hi, output logic stall_end);
    lat = -1;
    stall_hi = 0;
    stall_end = 1'b1;
    #1;
    if (stallreq_o) stall_hi++;
    for (int i = 1; i <= 100; i++) begin
      step();
      if (ready_o) begin
        lat = i;
        stall_end = stallreq_o;
        return;
      end
      if (stallreq_o) stall_hi++;
    end
  endtask

  task automatic retire();
    step();
    start_i = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step(); step(); step();
    checks++; if (ready_o !== 1'b0) begin errors++; $display("FAIL reset_ready: got %b want 0", ready_o); end
    checks++; if (result_o !== 64'd0) begin errors++; $display("FAIL reset_result: got %h want 0", result_o); end
    checks++; if (stallreq_o !== 1'b0) begin errors++; $display("FAIL reset_stall_lo: got %b want 0", stallreq_o); end
    start_i = 1'b1;
    #1;
    checks++; if (stallreq_o !== 1'b1) begin errors++; $display("FAIL reset_stall_follow: got %b want 1", stallreq_o); end
    start_i = 1'b0;
    step();
    rst = 1'b0;
    step();
  endtask

  task automatic test_divu();
    logic [31:0] a_tab [3] = '{32'd100, 32'hFFFF_FFFF, 32'd1234567};
    logic [31:0] b_tab [3] = '{32'd7, 32'h10, 32'd1000};
    exp_t e;
    int lat, shi;
    logic se;
    for (int i = 0; i < 3; i++) begin
      if (i == 0) issue_exp(a_tab[i], b_tab[i], 1'b0, {32'd2, 32'd14}, 33);
      else issue(a_tab[i], b_tab[i], 1'b0);
      wait_ready(lat, shi, se);
      e = sb.pop_front();
      checks++; if (lat !== e.lat) begin errors++; $display("FAIL divu_lat[%0d]: got %0d want %0d", i, lat, e.lat); end
      checks++; if (result_o !== e.res) begin errors++; $display("FAIL divu_res[%0d]: got %h want %h", i, result_o, e.res); end
      checks++; if (shi !== e.lat) begin errors++; $display("FAIL divu_stall_cycles[%0d]: got %0d want %0d", i, shi, e.lat); end
      checks++; if (se !== 1'b0) begin errors++; $display("FAIL divu_stall_end[%0d]: got %b want 0", i, se); end
      retire();
      checks++; if (ready_o !== 1'b0 || result_o !== 64'd0) begin errors++; $display("FAIL divu_free[%0d]: got ready=%b res=%h want 0/0", i, ready_o, result_o); end
    end
  endtask

  task automatic test_signed();
    logic [31:0] a_tab [5] = '{-32'sd7, 32'd7, 32'h8000_0000, -32'sd100, 32'h8000_0000};
    logic [31:0] b_tab [5] = '{32'd2, -32'sd2, 32'hFFFF_FFFF, 32'd7, 32'd1};
    logic [63:0] r_tab [3] = '{{32'hFFFF_FFFF, 32'hFFFF_FFFD},
                               {32'h0000_0001, 32'hFFFF_FFFD},
                               {32'h0000_0000, 32'h8000_0000}};
    exp_t e;
    int lat, shi;
    logic se;
    for (int i = 0; i < 5; i++) begin
      if (i < 3) issue_exp(a_tab[i], b_tab[i], 1'b1, r_tab[i], 33);
      else issue(a_tab[i], b_tab[i], 1'b1);
      wait_ready(lat, shi, se);
      e = sb.pop_front();
      checks++; if (lat !== e.lat) begin errors++; $display("FAIL div_lat[%0d]: got %0d want %0d", i, lat, e.lat); end
      checks++; if (result_o !== e.res) begin errors++; $display("FAIL div_res[%0d]: got %h want %h", i, result_o, e.res); end
      retire();
    end
  endtask

  task automatic test_div_by_zero();
    exp_t e;
    int lat, shi;
    logic se;
    issue_exp(32'd5, 32'd0, 1'b1, 64'd0, 2);
    wait_ready(lat, shi, se);
    e = sb.pop_front();
    checks++; if (lat !== e.lat) begin errors++; $display("FAIL dbz_lat: got %0d want %0d", lat, e.lat); end
    checks++; if (result_o !== e.res) begin errors++; $display("FAIL dbz_res: got %h want %h", result_o, e.res); end
    checks++; if (ready_o !== 1'b1) begin errors++; $display("FAIL dbz_ready: got %b want 1", ready_o); end
    checks++; if (shi !== 2) begin errors++; $display("FAIL dbz_stall_cycles: got %0d want 2", shi); end
    retire();
  endtask

  task automatic test_flush();
    exp_t e;
    int lat, shi;
    logic se;
    logic saw_ready = 1'b0;
    dividend_i = 32'hFFFF_FFFF; divisor_i = 32'd3; signed_i = 1'b0; start_i = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step();
      if (ready_o) saw_ready = 1'b1;
    end
    flush = 1'b1;
    #1;
    checks++; if (stallreq_o !== 1'b0) begin errors++; $display("FAIL flush_stall_mask: got %b want 0", stallreq_o); end
    step();
    flush = 1'b0;
    start_i = 1'b0;
    checks++; if (ready_o !== 1'b0 || saw_ready !== 1'b0) begin errors++; $display("FAIL flush_no_ready: got ready=%b seen=%b want 0/0", ready_o, saw_ready); end
    issue_exp(32'd9, 32'd3, 1'b1, {32'd0, 32'd3}, 33);
    wait_ready(lat, shi, se);
    e = sb.pop_front();
    checks++; if (lat !== e.lat) begin errors++; $display("FAIL flush_next_lat: got %0d want %0d", lat, e.lat); end
    checks++; if (result_o !== e.res) begin errors++; $display("FAIL flush_next_res: got %h want %h", result_o, e.res); end
    retire();
  endtask

  task automatic test_flush_at_start();
    exp_t e;
    int lat, shi;
    logic se;
    dividend_i = 32'd100; divisor_i = 32'd7; signed_i = 1'b0; start_i = 1'b1; flush = 1'b1;
    #1;
    checks++; if (stallreq_o !== 1'b0) begin errors++; $display("FAIL flush_start_stall: got %b want 0", stallreq_o); end
    step();
    flush = 1'b0;
    start_i = 1'b0;
    issue_exp(32'd5, 32'd0, 1'b0, 64'd0, 2);
    wait_ready(lat, shi, se);
    e = sb.pop_front();
    checks++; if (lat !== e.lat) begin errors++; $display("FAIL flush_start_lat: got %0d want %0d", lat, e.lat); end
    retire();
  endtask

  task automatic test_ex_stall();
    exp_t e;
    int lat, shi;
    logic se;
    logic [63:0] held;
    ex_stall_i = 1'b1;
    issue_exp(32'd100, 32'd7, 1'b0, {32'd2, 32'd14}, 33);
    wait_ready(lat, shi, se);
    e = sb.pop_front();
    checks++; if (lat !== e.lat) begin errors++; $display("FAIL stall_lat: got %0d want %0d", lat, e.lat); end
    checks++; if (result_o !== e.res) begin errors++; $display("FAIL stall_res: got %h want %h", result_o, e.res); end
    held = e.res;
    for (int k = 1; k <= 4; k++) begin
      step();
      checks++; if (ready_o !== 1'b1 || result_o !== held) begin errors++; $display("FAIL stall_hold[%0d]: got ready=%b res=%h want 1/%h", k, ready_o, result_o, held); end
      if (k == 3) ex_stall_i = 1'b1;
    end
    ex_stall_i = 1'b0;
    retire();
    checks++; if (ready_o !== 1'b0 || result_o !== 64'd0) begin errors++; $display("FAIL stall_release: got ready=%b res=%h want 0/0", ready_o, result_o); end
  endtask

  task automatic test_back_to_back();
    exp_t e;
    int lat, shi;
    logic se;
    issue(32'hFFFF_FFFF, 32'h10, 1'b0);
    wait_ready(lat, shi, se);
    e = sb.pop_front();
    checks++; if (lat !== e.lat || result_o !== e.res) begin errors++; $display("FAIL b2b_first: got lat=%0d res=%h want %0d/%h", lat, result_o, e.lat, e.res); end
    step();
    checks++; if (ready_o !== 1'b0) begin errors++; $display("FAIL b2b_free: got %b want 0", ready_o); end
    issue(-32'sd100, 32'd7, 1'b1);
    wait_ready(lat, shi, se);
    e = sb.pop_front();
    checks++; if (lat !== e.lat) begin errors++; $display("FAIL b2b_second_lat: got %0d want %0d", lat, e.lat); end
    checks++; if (result_o !== e.res) begin errors++; $display("FAIL b2b_second_res: got %h want %h", result_o, e.res); end
    retire();
  endtask

  task automatic test_operand_change();
    exp_t e;
    int lat, shi;
    logic se;
    issue_exp(32'd100, 32'd7, 1'b0, {32'd2, 32'd14}, 33);
    #1;
    for (int i = 0; i < 5; i++) step();
    dividend_i = 32'd12345; divisor_i = 32'd0; signed_i = 1'b1;
    wait_ready(lat, shi, se);
    e = sb.pop_front();
    checks++; if (lat !== e.lat - 5) begin errors++; $display("FAIL opchg_lat: got %0d want %0d", lat, e.lat - 5); end
    checks++; if (result_o !== e.res) begin errors++; $display("FAIL opchg_res: got %h want %h", result_o, e.res); end
    retire();
  endtask

  task automatic test_reset_mid_op();
    exp_t e;
    int lat, shi;
    logic se;
    dividend_i = 32'd100; divisor_i = 32'd7; signed_i = 1'b0; start_i = 1'b1;
    for (int i = 0; i < 5; i++) step();
    rst = 1'b1;
    step();
    checks++; if (ready_o !== 1'b0 || result_o !== 64'd0) begin errors++; $display("FAIL rst_mid: got ready=%b res=%h want 0/0", ready_o, result_o); end
    rst = 1'b0;
    issue_exp(32'd5, 32'd0, 1'b0, 64'd0, 2);
    wait_ready(lat, shi, se);
    e = sb.pop_front();
    checks++; if (lat !== e.lat) begin errors++; $display("FAIL rst_mid_next_lat: got %0d want %0d", lat, e.lat); end
    retire();
  endtask

  task automatic test_early_term();
    exp_t e;
    int lat, shi;
    logic se;
`ifdef DIV_EARLY_TERM_EN
    issue_exp(32'd3, 32'd10, 1'b0, {32'd3, 32'd0}, 2);
`else
    issue_exp(32'd3, 32'd10, 1'b0, {32'd3, 32'd0}, 33);
`endif
    wait_ready(lat, shi, se);
    e = sb.pop_front();
    checks++; if (lat !== e.lat) begin errors++; $display("FAIL early_lat: got %0d want %0d", lat, e.lat); end
    checks++; if (result_o !== e.res) begin errors++; $display("FAIL early_res: got %h want %h", result_o, e.res); end
    retire();
    issue(-32'sd3, 32'd10, 1'b1);
    wait_ready(lat, shi, se);
    e = sb.pop_front();
    checks++; if (lat !== e.lat || result_o !== e.res) begin errors++; $display("FAIL early_signed: got lat=%0d res=%h want %0d/%h", lat, result_o, e.lat, e.res); end
    retire();
  endtask

  initial begin
    test_reset();
    test_divu();
    test_signed();
    test_div_by_zero();
    test_flush();
    test_flush_at_start();
    test_ex_stall();
    test_back_to_back();
    test_operand_change();
    test_reset_mid_op();
    test_early_term();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
